// File: rtl/mul_defs.sv
// Shared definitions for the iterative multiplier: FSM state encodings and
// result half-select constants used on the A bus.
package mul_defs;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_FIX  = 2'd2
  } mul_state_t;

  localparam logic MUL_LO = 1'b0;
  localparam logic MUL_HI = 1'b1;

endpackage

// File: rtl/mul_step.sv
// One radix-2^K iteration: partial product of the multiplicand and one K-bit
// multiplier digit, added into the running product at offset idx*K.
module mul_step #(
  parameter int WIDTH = 32,
  parameter int K     = 8,
  parameter int CW    = 2
) (
  input  logic [WIDTH-1:0]   mcand,
  input  logic [K-1:0]       digit,
  input  logic [CW-1:0]      idx,
  input  logic [2*WIDTH-1:0] prod_in,
  output logic [2*WIDTH-1:0] prod_out
);

  logic [WIDTH+K-1:0] pp;
  logic [2*WIDTH-1:0] pp_ext;

  assign pp       = (WIDTH+K)'(mcand) * (WIDTH+K)'(digit);
  assign pp_ext   = (2*WIDTH)'(pp);
  assign prod_out = prod_in + (pp_ext << (idx * K));

endmodule

// File: rtl/mul_iter.sv
// Multi-cycle iterative multiplier for the MUL/MLA/xMULL/xMLAL family.
// Multiplies magnitudes K bits per cycle, then fixes sign and adds the addend.
module mul_iter
  import mul_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 8
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] ACC_LO,
  input  logic [WIDTH-1:0] ACC_HI,
  input  logic             ACC,
  input  logic             U,
  input  logic             LD_MUL,
  input  logic             Gate_MUL,
  input  logic             MUL_HiLo,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / K;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (K < 1 || (WIDTH % K) != 0) begin : g_bad_k
    $error("mul_iter: K=%0d must divide WIDTH=%0d", K, WIDTH);
  end

  mul_state_t         state;
  logic [WIDTH-1:0]   mcand, mplier;
  logic               neg;
  logic [2*WIDTH-1:0] acc_r, prod, prod_nxt, result;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             last;

  // Signed operands are reduced to unsigned magnitudes; the most negative
  // value maps onto itself, which is the correct unsigned magnitude.
  assign a_mag = (!U && A[WIDTH-1]) ? -A : A;
  assign b_mag = (!U && B[WIDTH-1]) ? -B : B;
  assign last  = (cnt == CW'(N - 1));

  mul_step #(.WIDTH(WIDTH), .K(K), .CW(CW)) u_step (
    .mcand   (mcand),
    .digit   (mplier[K-1:0]),
    .idx     (cnt),
    .prod_in (prod),
    .prod_out(prod_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MUL_IDLE;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      acc_r  <= '0;
      prod   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MUL_IDLE: begin
          if (LD_MUL) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= ~U & (A[WIDTH-1] ^ B[WIDTH-1]);
            acc_r  <= ACC ? {ACC_HI, ACC_LO} : '0;
            prod   <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          prod   <= prod_nxt;
          mplier <= mplier >> K;
          if (last) begin
            cnt   <= '0;
            state <= MUL_FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MUL_FIX: begin
          result <= (neg ? -prod : prod) + acc_r;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= MUL_IDLE;
        end
        default: state <= MUL_IDLE;
      endcase
    end
  end

  assign A = Gate_MUL ? ((MUL_HiLo == MUL_HI) ? result[2*WIDTH-1:WIDTH] : result[WIDTH-1:0])
                      : {WIDTH{1'bz}};

endmodule
